// File: rtl/b_resp_router_pkg.sv
// Shared constants for the B-channel response router.
// FIFO word layout, master select values, BRESP codes, slot state.
package b_resp_router_pkg;

  localparam int S_B_DATASIZE = 10;

  localparam int SEL_M0 = 0;
  localparam int SEL_M1 = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/b_out_slot.sv
// One-entry registered B-channel output slot for a single master.
// in: load, ld_id, ld_resp, BREADY; out: BVALID, BID, BRESP, can_accept.
module b_out_slot
  import b_resp_router_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic            load,
  input  logic [ID_W-1:0] ld_id,
  input  logic [1:0]      ld_resp,
  input  logic            BREADY,
  output logic            BVALID,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  output logic            can_accept
);

  slot_state_e state, state_nxt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= SLOT_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (BREADY && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BID   <= '0;
      BRESP <= '0;
    end else if (load) begin
      BID   <= ld_id;
      BRESP <= ld_resp;
    end
  end

  // BVALID is purely registered; only can_accept sees BREADY.
  assign BVALID     = (state == SLOT_FULL);
  assign can_accept = (state == SLOT_EMPTY) || BREADY;

endmodule

// File: rtl/b_resp_router.sv
// Pops B responses from the async FIFO and routes them to M0/M1 slots.
// in: fifo_rdata/rempty, BREADY_Mx; out: fifo_rpop, B*_Mx, err_unroutable.
module b_resp_router
  import b_resp_router_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int ID_W  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [S_B_DATASIZE-1:0] fifo_rdata,
  input  logic                    fifo_rempty,
  output logic                    fifo_rpop,
  output logic [ID_W-1:0]         BID_M0,
  output logic [1:0]              BRESP_M0,
  output logic                    BVALID_M0,
  input  logic                    BREADY_M0,
  output logic [ID_W-1:0]         BID_M1,
  output logic [1:0]              BRESP_M1,
  output logic                    BVALID_M1,
  input  logic                    BREADY_M1,
  output logic                    err_unroutable
);

  logic [SEL_W-1:0] sel;
  logic [ID_W-1:0]  id;
  logic [1:0]       resp;
  logic             hit0, hit1;
  logic             acc0, acc1;
  logic             tgt_ok, unr;
  logic             ld0, ld1;

  assign sel  = fifo_rdata[S_B_DATASIZE-1 -: SEL_W];
  assign id   = fifo_rdata[2 +: ID_W];
  assign resp = fifo_rdata[1:0];
  assign hit0 = (sel == SEL_W'(SEL_M0));
  assign hit1 = (sel == SEL_W'(SEL_M1));

  // Strict in-order: only the head's own target gates the pop.
  always_comb begin
    tgt_ok = 1'b1;
    unr    = 1'b0;
    unique case (1'b1)
      hit0:    tgt_ok = acc0;
      hit1:    tgt_ok = acc1;
      default: unr    = 1'b1;
    endcase
  end

  // Gated by ARESETn: both slots read EMPTY during reset.
  assign fifo_rpop = ARESETn && !fifo_rempty && tgt_ok;
  assign ld0       = fifo_rpop && hit0;
  assign ld1       = fifo_rpop && hit1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)             err_unroutable <= 1'b0;
    else if (fifo_rpop && unr) err_unroutable <= 1'b1;
  end

  b_out_slot #(.ID_W(ID_W)) u_slot_m0 (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .load       (ld0),
    .ld_id      (id),
    .ld_resp    (resp),
    .BREADY     (BREADY_M0),
    .BVALID     (BVALID_M0),
    .BID        (BID_M0),
    .BRESP      (BRESP_M0),
    .can_accept (acc0)
  );

  b_out_slot #(.ID_W(ID_W)) u_slot_m1 (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .load       (ld1),
    .ld_id      (id),
    .ld_resp    (resp),
    .BREADY     (BREADY_M1),
    .BVALID     (BVALID_M1),
    .BID        (BID_M1),
    .BRESP      (BRESP_M1),
    .can_accept (acc1)
  );

endmodule

// File: tb/tb_b_resp_router.sv
// Scoreboard bench for b_resp_router with a queue-based FIFO model.
// Directed reset/latency/HOL/error cases plus randomized traffic.
module tb_b_resp_router;
  import b_resp_router_pkg::*;

  localparam int SEL_W = 4;
  localparam int ID_W  = 4;
  localparam int DW    = S_B_DATASIZE;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty;
  logic          fifo_rpop;
  logic [ID_W-1:0] BID_M0, BID_M1;
  logic [1:0]    BRESP_M0, BRESP_M1;
  logic          BVALID_M0, BVALID_M1;
  logic          BREADY_M0 = 1'b0;
  logic          BREADY_M1 = 1'b0;
  logic          err_unroutable;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [5:0]    exp0[$];
  logic [5:0]    exp1[$];
  logic          err_exp = 1'b0;
  logic          pop_s = 1'b0;
  logic          lp_valid = 1'b0;
  logic [DW-1:0] lp_word = '0;
  logic          held0 = 1'b0, held1 = 1'b0;
  logic [5:0]    hv0 = '0, hv1 = '0;

  b_resp_router #(.SEL_W(SEL_W), .ID_W(ID_W)) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .fifo_rdata     (fifo_rdata),
    .fifo_rempty    (fifo_rempty),
    .fifo_rpop      (fifo_rpop),
    .BID_M0         (BID_M0),
    .BRESP_M0       (BRESP_M0),
    .BVALID_M0      (BVALID_M0),
    .BREADY_M0      (BREADY_M0),
    .BID_M1         (BID_M1),
    .BRESP_M1       (BRESP_M1),
    .BVALID_M1      (BVALID_M1),
    .BREADY_M1      (BREADY_M1),
    .err_unroutable (err_unroutable)
  );

  always #5 ACLK = ~ACLK;

  function automatic int route(input logic [DW-1:0] w);
    logic [SEL_W-1:0] s;
    s = w[DW-1 -: SEL_W];
    if (s == SEL_W'(SEL_M0)) return 0;
    if (s == SEL_W'(SEL_M1)) return 1;
    return 2;
  endfunction

  function automatic void refresh();
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = fifo_rempty ? '0 : fifo_q[0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input int id, input int resp);
    logic [DW-1:0] w;
    w = {sel[SEL_W-1:0], id[ID_W-1:0], resp[1:0]};
    fifo_q.push_back(w);
    if (route(w) == 0) exp0.push_back(w[5:0]);
    else if (route(w) == 1) exp1.push_back(w[5:0]);
    refresh();
  endtask

  // FIFO read side: head advances after an edge where pop was seen.
  initial begin
    refresh();
    forever begin
      @(posedge ACLK);
      #1;
      if (pop_s && ARESETn && fifo_q.size() > 0) begin
        lp_word  = fifo_q.pop_front();
        lp_valid = 1'b1;
        if (route(lp_word) == 2) err_exp = 1'b1;
        refresh();
      end
    end
  end

  // Monitor: pop rule, latency, scoreboard, AXI stability, error flag.
  always @(negedge ACLK) begin
    int  r;
    logic ep;
    if (!ARESETn) begin
      pop_s = 1'b0;
      lp_valid = 1'b0;
      held0 = 1'b0;
      held1 = 1'b0;
    end else begin
      r = (fifo_q.size() > 0) ? route(fifo_q[0]) : -1;
      ep = (r == 2) ||
           (r == 0 && !(BVALID_M0 && !BREADY_M0)) ||
           (r == 1 && !(BVALID_M1 && !BREADY_M1));
      chk("rpop", {31'd0, fifo_rpop}, {31'd0, ep});
      pop_s = fifo_rpop;
      if (lp_valid) begin
        r = route(lp_word);
        if (r == 0)
          chk("lat_m0", {25'd0, BVALID_M0, BID_M0, BRESP_M0},
              {25'd0, 1'b1, lp_word[5:0]});
        else if (r == 1)
          chk("lat_m1", {25'd0, BVALID_M1, BID_M1, BRESP_M1},
              {25'd0, 1'b1, lp_word[5:0]});
        lp_valid = 1'b0;
      end
      if (held0)
        chk("stable_m0", {25'd0, BVALID_M0, BID_M0, BRESP_M0},
            {25'd0, 1'b1, hv0});
      if (held1)
        chk("stable_m1", {25'd0, BVALID_M1, BID_M1, BRESP_M1},
            {25'd0, 1'b1, hv1});
      held0 = BVALID_M0 && !BREADY_M0;
      hv0   = {BID_M0, BRESP_M0};
      held1 = BVALID_M1 && !BREADY_M1;
      hv1   = {BID_M1, BRESP_M1};
      if (BVALID_M0 && BREADY_M0) begin
        if (exp0.size() == 0) chk("sb_m0_extra", 32'd1, 32'd0);
        else chk("sb_m0", {26'd0, BID_M0, BRESP_M0},
                 {26'd0, exp0.pop_front()});
      end
      if (BVALID_M1 && BREADY_M1) begin
        if (exp1.size() == 0) chk("sb_m1_extra", 32'd1, 32'd0);
        else chk("sb_m1", {26'd0, BID_M1, BRESP_M1},
                 {26'd0, exp1.pop_front()});
      end
      chk("err", {31'd0, err_unroutable}, {31'd0, err_exp});
    end
  end

  initial begin
    int n;
    int s;

    // Reset with a non-empty FIFO.
    BREADY_M0 = 1'b1;
    push(0, 3, 0);
    repeat (2) @(negedge ACLK);
    chk("rst_rpop", {31'd0, fifo_rpop}, 32'd0);
    chk("rst_bv", {30'd0, BVALID_M1, BVALID_M0}, 32'd0);
    chk("rst_bid", {24'd0, BID_M1, BID_M0}, 32'd0);
    chk("rst_bresp", {28'd0, BRESP_M1, BRESP_M0}, 32'd0);
    chk("rst_err", {31'd0, err_unroutable}, 32'd0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;

    // First pop right after release, one-cycle latency, then drain.
    @(negedge ACLK);
    chk("first_pop", {31'd0, fifo_rpop}, 32'd1);
    @(negedge ACLK);
    chk("m0_bv", {25'd0, BVALID_M0, BID_M0, BRESP_M0}, {25'd0, 7'h4c});
    @(negedge ACLK);
    chk("m0_drop", {31'd0, BVALID_M0}, 32'd0);

    // Four M1 responses back-to-back with BREADY held high.
    @(posedge ACLK);
    #1;
    BREADY_M1 = 1'b1;
    for (int i = 1; i <= 4; i++) push(1, i, 2);
    @(negedge ACLK);
    for (int i = 1; i <= 4; i++) begin
      @(negedge ACLK);
      chk("m1_burst", {27'd0, BVALID_M1, BID_M1},
          {27'd0, 1'b1, i[3:0]});
    end
    @(negedge ACLK);
    chk("m1_burst_end", {31'd0, BVALID_M1}, 32'd0);

    // Head-of-line stall: M0 blocked, M1 word waits behind it.
    @(posedge ACLK);
    #1;
    BREADY_M0 = 1'b0;
    push(0, 7, 2);
    push(0, 8, 3);
    push(1, 9, 0);
    repeat (5) @(negedge ACLK);
    chk("hol_depth", fifo_q.size(), 32'd2);
    chk("hol_m1_idle", {31'd0, BVALID_M1}, 32'd0);
    @(posedge ACLK);
    #1 BREADY_M0 = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("hol_flushed", fifo_q.size(), 32'd0);

    // Unroutable select is dropped and flagged.
    @(posedge ACLK);
    #1 push(5, 6, 3);
    repeat (3) @(negedge ACLK);
    chk("unr_err", {31'd0, err_unroutable}, 32'd1);
    chk("unr_nobv", {30'd0, BVALID_M1, BVALID_M0}, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(posedge ACLK);
      #1;
      BREADY_M0 = ($urandom_range(0, 3) != 0);
      BREADY_M1 = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) == 0) s = int'($urandom_range(2, 15));
        else s = int'($urandom_range(0, 1));
        push(s, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
    end

    // Drain with a bounded wait.
    @(posedge ACLK);
    #1;
    BREADY_M0 = 1'b1;
    BREADY_M1 = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || exp0.size() != 0 || exp1.size() != 0)
           && n < 200) begin
      @(posedge ACLK);
      #1 n++;
    end
    chk("drain_done", {31'd0, (n < 200)}, 32'd1);

    // Asynchronous reset while the M0 slot holds a response.
    BREADY_M0 = 1'b0;
    push(0, 5, 3);
    repeat (3) @(negedge ACLK);
    chk("pre_rst_bv", {31'd0, BVALID_M0}, 32'd1);
    @(posedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_bv", {31'd0, BVALID_M0}, 32'd0);
    chk("async_bid", {28'd0, BID_M0}, 32'd0);
    chk("async_err", {31'd0, err_unroutable}, 32'd0);
    chk("async_rpop", {31'd0, fifo_rpop}, 32'd0);
    fifo_q.delete();
    exp0.delete();
    exp1.delete();
    err_exp = 1'b0;
    refresh();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
